lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V core; consumes the EX-stage outputs (ALU result as address, store data, mem/wb control, Rd).
- Issues loads and stores on a req/gnt/rvalid data bus and aligns byte lanes.
- Sign- or zero-extends load data and registers the results for WB.
- Drives the forwarding view (Rd, wb ctrl, data) back to EX and asserts hold_o to stall the pipeline while an access is outstanding.

Parameters:
- ADDR_W, 32, data-bus address width.
- DATA_W, 32, data-bus data width; fixed at 32.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_arst  in  1  asynchronous active-high reset.
- valid_i  in  1  EX/MEM register holds a real instruction.
- result_i  in  32  ALU result; used as the effective address for loads and stores.
- reg2_r_data_i  in  32  store data, already forwarded.
- mem_ctrl_i  in  15  memory control. Bit[5] MemWrite, bit[4] MemRead, bits[2:0] funct3. Other bits ignored.
- wb_ctrl_i  in  2  writeback control; passed through.
- ex_Rd_i  in  5  destination register.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  1 = store.
- dbus_addr_o  out  32  word-aligned address, {result_i[31:2],2'b00}.
- dbus_wdata_o  out  32  lane-replicated store data.
- dbus_be_o  out  4  byte enables.
- dbus_gnt_i  in  1  request accepted.
- dbus_rvalid_i  in  1  load data valid.
- dbus_rdata_i  in  32  load data.
- mem_Rd_o  out  5  forwarding Rd; equals ex_Rd_i.
- mem_wb_ctrl_o  out  2  forwarding ctrl; wb_ctrl_i gated by valid_i.
- mem_data_o  out  32  forwarding data; equals result_i.
- wb_data_o  out  32  registered result to WB.
- wb_Rd_o  out  5  registered Rd.
- wb_ctrl_o  out  2  registered wb ctrl; 0 means bubble.
- err_o  out  1  one-cycle pulse on a misaligned or illegal access.
- hold_o  out  1  stall request to all upstream stages.

Behaviour:
- Reset (async, immediate): state=IDLE; dbus_req_o=0; wb_data_o, wb_Rd_o, wb_ctrl_o, err_o all 0. A reset during WAIT_GNT or WAIT_RSP abandons the access, and a late rvalid is ignored.
- mem_op = valid_i & (MemRead | MemWrite). If both MemRead and MemWrite are set, the access is treated as a store.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal.
- Misaligned: H access with addr[0]=1, or W access with addr[1:0]≠0.
- Illegal or misaligned access: no bus request; err_o=1 next cycle; the WB register receives a bubble (wb_ctrl_o=0); hold_o=0.
- FSM states: IDLE, WAIT_GNT, WAIT_RSP.
  - IDLE: dbus_req_o = legal mem_op (combinational).
    - gnt=1 on a store: done; stay in IDLE.
    - gnt=1 on a load: go to WAIT_RSP.
    - gnt=0: go to WAIT_GNT.
  - WAIT_GNT: dbus_req_o=1.
    - gnt on a store: go to IDLE.
    - gnt on a load: go to WAIT_RSP.
  - WAIT_RSP: dbus_req_o=0.
    - dbus_rvalid_i=1: go to IDLE (load complete).
- Bus rules:
  - req, we, addr, wdata and be stay stable from assertion until gnt; upstream holds its inputs stable while hold_o=1.
  - rvalid arrives no earlier than the cycle after gnt.
  - rvalid outside WAIT_RSP is ignored.
- hold_o (combinational) is 1 in any of these cases:
  - IDLE with a legal mem_op and gnt=0;
  - IDLE with a legal load;
  - WAIT_GNT, unless the access is a store and gnt=1;
  - WAIT_RSP with rvalid=0.
- Stage advance = ~hold_o. On advance the WB register loads:
  - wb_Rd_o = ex_Rd_i; wb_ctrl_o = wb_ctrl_i & {2{valid_i}} (0 on err).
  - wb_data_o = the extended load word for a load; otherwise result_i.
  - While hold_o=1, the WB register loads a bubble (wb_ctrl_o=0), so a retiring instruction writes only once.
- Latency (cycles for which hold_o=1):
  - store with immediate gnt: 0;
  - load with immediate gnt and rvalid one cycle later: 1 stall cycle;
  - each wait cycle on gnt or rvalid adds 1.
- Store lanes, with offset = addr[1:0]:
  - SB: be=4'b0001<<offset; wdata = byte replicated ×4.
  - SH: be=4'b0011<<{offset[1],1'b0}; wdata = half replicated ×2.
  - SW: be=4'b1111.
- Loads: dbus_be_o=4'b1111.
  - LB/LBU: select byte rdata[8*offset+:8], then sign- or zero-extend.
  - LH/LHU: select half rdata[16*offset[1]+:16], then sign- or zero-extend.
  - LW: pass through.
- Non-memory instructions: no bus activity; hold_o=0; pass-through to WB in 1 cycle.

Test Plan:
- ALU op (result_i=0x1234, wb_ctrl_i=2'b01, Rd=5, valid) -> next cycle wb_data_o=0x1234, wb_Rd_o=5, wb_ctrl_o=01; dbus_req_o never asserted.
- SW addr 0x100, data 0xDEADBEEF, gnt in the same cycle -> dbus_be_o=1111, dbus_wdata_o=0xDEADBEEF, hold_o=0.
- SB addr 0x103, data 0x000000A5, gnt delayed 2 cycles -> be=1000, wdata=0xA5A5A5A5, hold_o=1 for 2 cycles, request stable throughout.
- LB addr 0x202, rdata 0x00800000 arriving 3 cycles after gnt -> wb_data_o=0xFFFFFF80; with LBU the same access -> 0x00000080; hold_o deasserts in the rvalid cycle.
- LHU addr 0x203 -> no request, err_o=1 for one cycle, wb_ctrl_o=0; LH addr 0x202, rdata 0x80010000 -> wb_data_o=0xFFFF8001.
- sys_arst asserted in WAIT_RSP -> dbus_req_o=0, hold_o=0, wb_ctrl_o=0 immediately; an rvalid pulse after release has no effect.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid bus, aligns byte lanes,
// extends load data and registers the result for writeback, stalling upstream while busy.
module lsu_mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_arst,
  input  logic              valid_i,
  input  logic [31:0]       result_i,
  input  logic [DATA_W-1:0] reg2_r_data_i,
  input  logic [14:0]       mem_ctrl_i,
  input  logic [1:0]        wb_ctrl_i,
  input  logic [4:0]        ex_Rd_i,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  output logic [3:0]        dbus_be_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [DATA_W-1:0] dbus_rdata_i,
  output logic [4:0]        mem_Rd_o,
  output logic [1:0]        mem_wb_ctrl_o,
  output logic [31:0]       mem_data_o,
  output logic [31:0]       wb_data_o,
  output logic [4:0]        wb_Rd_o,
  output logic [1:0]        wb_ctrl_o,
  output logic              err_o,
  output logic              hold_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;

  typedef struct packed {
    logic       load;
    logic       store;
    logic [2:0] f3;
    logic [1:0] off;
  } acc_t;

  state_t state, state_n;
  acc_t   acc;
  logic   mem_op, f3_ok, misal, bad, legal;
  logic   req, hold;
  logic [3:0][7:0] rd_lanes;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_ext;
  logic            unused;

  assign unused = ^{mem_ctrl_i[14:6], mem_ctrl_i[3]};

  // Both MemRead and MemWrite set resolves to a store.
  assign acc.store = valid_i & mem_ctrl_i[5];
  assign acc.load  = valid_i & mem_ctrl_i[4] & ~mem_ctrl_i[5];
  assign acc.f3    = mem_ctrl_i[2:0];
  assign acc.off   = result_i[1:0];
  assign mem_op    = acc.store | acc.load;

  always_comb begin
    f3_ok = 1'b0;
    if (acc.store)
      f3_ok = (acc.f3 == 3'b000) || (acc.f3 == 3'b001) || (acc.f3 == 3'b010);
    else
      f3_ok = (acc.f3 == 3'b000) || (acc.f3 == 3'b001) || (acc.f3 == 3'b010) ||
              (acc.f3 == 3'b100) || (acc.f3 == 3'b101);
  end

  assign misal = ((acc.f3[1:0] == 2'b01) & acc.off[0]) |
                 ((acc.f3[1:0] == 2'b10) & (acc.off != 2'b00));
  assign bad   = mem_op & (~f3_ok | misal);
  assign legal = mem_op & ~bad;

  always_ff @(posedge sys_clk or posedge sys_arst) begin
    if (sys_arst) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    req     = 1'b0;
    hold    = 1'b0;
    case (state)
      IDLE: begin
        req  = legal;
        hold = legal & (acc.load | ~dbus_gnt_i);
        if (legal) begin
          if (!dbus_gnt_i)     state_n = WAIT_GNT;
          else if (acc.load)   state_n = WAIT_RSP;
        end
      end
      WAIT_GNT: begin
        req  = 1'b1;
        hold = ~(acc.store & dbus_gnt_i);
        if (dbus_gnt_i) state_n = acc.store ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: begin
        hold = ~dbus_rvalid_i;
        if (dbus_rvalid_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Gated by reset so an abandoned access drops the bus and releases the pipe at once.
  assign dbus_req_o = req & ~sys_arst;
  assign hold_o     = hold & ~sys_arst;

  assign dbus_we_o   = acc.store;
  assign dbus_addr_o = {result_i[ADDR_W-1:2], 2'b00};

  always_comb begin
    dbus_be_o    = 4'b1111;
    dbus_wdata_o = reg2_r_data_i;
    if (acc.store) begin
      case (acc.f3[1:0])
        2'b00: begin
          dbus_be_o    = 4'b0001 << acc.off;
          dbus_wdata_o = {4{reg2_r_data_i[7:0]}};
        end
        2'b01: begin
          dbus_be_o    = 4'b0011 << {acc.off[1], 1'b0};
          dbus_wdata_o = {2{reg2_r_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign rd_lanes = dbus_rdata_i;
  assign ld_byte  = rd_lanes[acc.off];
  assign ld_half  = acc.off[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];

  always_comb begin
    case (acc.f3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'b0, ld_byte};
      3'b101:  ld_ext = {16'b0, ld_half};
      default: ld_ext = dbus_rdata_i;
    endcase
  end

  assign mem_Rd_o      = ex_Rd_i;
  assign mem_wb_ctrl_o = wb_ctrl_i & {2{valid_i}};
  assign mem_data_o    = result_i;

  // While stalled the WB register takes a bubble so the retiring op writes exactly once.
  always_ff @(posedge sys_clk or posedge sys_arst) begin
    if (sys_arst) begin
      wb_data_o <= '0;
      wb_Rd_o   <= '0;
      wb_ctrl_o <= '0;
      err_o     <= 1'b0;
    end else begin
      err_o <= (state == IDLE) & bad;
      if (hold) begin
        wb_ctrl_o <= '0;
      end else begin
        wb_Rd_o   <= ex_Rd_i;
        wb_ctrl_o <= bad ? 2'b00 : (wb_ctrl_i & {2{valid_i}});
        wb_data_o <= (state == WAIT_RSP) ? ld_ext : result_i;
      end
    end
  end

endmodule
